// File: rtl/fp16_mul_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_mul_seq_pkg
//  Description : Shared types and constants for the sequential binary16
//                multiplier (field widths, FSM encoding, special values).
//  Revision    : 1.0  initial release
// ============================================================================
package fp16_mul_seq_pkg;

    // binary16 field layout
    localparam int SIGN_W     = 1;
    localparam int EXP_W      = 5;
    localparam int MANT_W     = 10;
    localparam int FP_W       = SIGN_W + EXP_W + MANT_W;

    // datapath sizing
    localparam int SIG_W      = MANT_W + 1;   // significand with hidden one
    localparam int PROD_W     = 2 * SIG_W;    // full significand product
    localparam int EXP_CALC_W = 7;            // signed working exponent
    localparam int CNT_W      = 4;            // shift-add iteration counter

    localparam int BIAS = 15;

    localparam logic [EXP_W-1:0]             EXP_MAX  = 5'b11111;
    localparam logic [FP_W-1:0]              QNAN     = 16'h7E00;
    localparam logic signed [EXP_CALC_W-1:0] BIAS_EXT = 7'sd15;
    localparam logic signed [EXP_CALC_W-1:0] EXP_OVF  = 7'sd31;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_MULT  = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp16_t;

endpackage
`default_nettype wire

// File: rtl/fp16_mul_seq_special.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_special_detect
//  Description : Combinational classifier for NaN / infinity / zero /
//                subnormal operands; produces the final product when the
//                pair never needs the significand multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
module fp16_special_detect
    import fp16_mul_seq_pkg::*;
(
    input  logic              sign_a_i,
    input  logic              sign_b_i,
    input  logic [EXP_W-1:0]  exp_a_i,
    input  logic [EXP_W-1:0]  exp_b_i,
    input  logic [MANT_W-1:0] mant_a_i,
    input  logic [MANT_W-1:0] mant_b_i,
    output logic [FP_W-1:0]   q_o,
    output logic              exc_o
);

    logic sign_p;
    logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, sub_a, sub_b;
    logic [MANT_W-1:0] mant_min;

    assign sign_p   = sign_a_i ^ sign_b_i;
    assign nan_a    = (exp_a_i == EXP_MAX) && (mant_a_i != '0);
    assign nan_b    = (exp_b_i == EXP_MAX) && (mant_b_i != '0);
    assign inf_a    = (exp_a_i == EXP_MAX) && (mant_a_i == '0);
    assign inf_b    = (exp_b_i == EXP_MAX) && (mant_b_i == '0);
    assign zero_a   = (exp_a_i == '0) && (mant_a_i == '0);
    assign zero_b   = (exp_b_i == '0) && (mant_b_i == '0);
    assign sub_a    = (exp_a_i == '0) && (mant_a_i != '0);
    assign sub_b    = (exp_b_i == '0) && (mant_b_i != '0);
    assign mant_min = (mant_a_i < mant_b_i) ? mant_a_i : mant_b_i;

    // First matching rule wins; subnormals are the lowest-priority case and
    // are flushed to a signed zero.
    always_comb begin
        q_o   = '0;
        exc_o = 1'b1;
        if (nan_a && nan_b) begin
            q_o = {sign_p, EXP_MAX, mant_min};
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            q_o = QNAN;
        end else if (nan_a) begin
            q_o = {sign_a_i, exp_a_i, mant_a_i};
        end else if (nan_b) begin
            q_o = {sign_b_i, exp_b_i, mant_b_i};
        end else if (inf_a || inf_b) begin
            q_o = {sign_p, EXP_MAX, {MANT_W{1'b0}}};
        end else if (zero_a || zero_b || sub_a || sub_b) begin
            q_o = {sign_p, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
        end else begin
            exc_o = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_mul_seq
//  Description : Multi-cycle IEEE-754 binary16 multiplier. Special operands
//                resolve in one step; normal operands run an 11-cycle
//                shift-add significand multiply, then normalise and round
//                to nearest-even.
//  Revision    : 1.0  initial release
// ============================================================================
module fp16_mul_seq
    import fp16_mul_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] q,
    output logic            exc,
    output logic            busy
);

    state_t                        state_q, state_d;
    fp16_t                         a_q, a_d, b_q, b_d;
    logic [PROD_W-1:0]             acc_q, acc_d;
    logic [PROD_W-1:0]             mcand_q, mcand_d;
    logic signed [EXP_CALC_W-1:0]  exp_q, exp_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [FP_W-1:0]               res_q, res_d;
    logic                          exc_q, exc_d;

    logic [FP_W-1:0]               spec_q;
    logic                          spec_exc;

    fp16_special_detect u_special (
        .sign_a_i (a_q.sign),
        .sign_b_i (b_q.sign),
        .exp_a_i  (a_q.exp),
        .exp_b_i  (b_q.exp),
        .mant_a_i (a_q.mant),
        .mant_b_i (b_q.mant),
        .q_o      (spec_q),
        .exc_o    (spec_exc)
    );

    // Multiplier bit for the current iteration, taken LSB first from {1,mant_b}
    logic [SIG_W-1:0] mplier_sh;
    logic             mbit;
    assign mplier_sh = {1'b1, b_q.mant} >> cnt_q;
    assign mbit      = mplier_sh[0];

    // Normalise / round path, evaluated from the finished accumulator
    logic                         sign_p, norm_shift, guard, sticky, round_up;
    logic [MANT_W-1:0]            mant_pre;
    logic [MANT_W:0]              mant_rnd;
    logic signed [EXP_CALC_W-1:0] exp_n, exp_r;

    assign sign_p     = a_q.sign ^ b_q.sign;
    assign norm_shift = acc_q[PROD_W-1];
    assign mant_pre   = norm_shift ? acc_q[PROD_W-2 -: MANT_W] : acc_q[PROD_W-3 -: MANT_W];
    assign guard      = norm_shift ? acc_q[MANT_W] : acc_q[MANT_W-1];
    assign sticky     = norm_shift ? (|acc_q[MANT_W-1:0]) : (|acc_q[MANT_W-2:0]);
    assign round_up   = guard & (sticky | mant_pre[0]);
    assign mant_rnd   = {1'b0, mant_pre} + {{MANT_W{1'b0}}, round_up};
    assign exp_n      = exp_q + $signed({{(EXP_CALC_W-1){1'b0}}, norm_shift});
    assign exp_r      = exp_n + $signed({{(EXP_CALC_W-1){1'b0}}, mant_rnd[MANT_W]});

    // State and datapath registers; reset discards any job in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    // Next-state and datapath update for each phase of a job
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        exc_d   = exc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                acc_d   = '0;
                mcand_d = {{(PROD_W-SIG_W){1'b0}}, 1'b1, a_q.mant};
                cnt_d   = '0;
                if (spec_exc) begin
                    res_d   = spec_q;
                    exc_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                if (mbit) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                exp_d   = $signed({{(EXP_CALC_W-EXP_W){1'b0}}, a_q.exp})
                        + $signed({{(EXP_CALC_W-EXP_W){1'b0}}, b_q.exp})
                        - BIAS_EXT;
                if (cnt_q == CNT_W'(SIG_W-1)) begin
                    cnt_d   = '0;
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_NORM: begin
                if (exp_r >= EXP_OVF) begin
                    res_d = {sign_p, EXP_MAX, {MANT_W{1'b0}}};
                    exc_d = 1'b1;
                end else if (exp_r <= $signed({EXP_CALC_W{1'b0}})) begin
                    res_d = {sign_p, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
                    exc_d = 1'b1;
                end else begin
                    res_d = {sign_p, exp_r[EXP_W-1:0], mant_rnd[MANT_W-1:0]};
                    exc_d = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign q         = res_q;
    assign exc       = exc_q;

endmodule
`default_nettype wire
